keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4, meaning the number of consecutive matching scan_tick samples that accept a press or a release; legal range 2..15.
REQ-002 SHALL have port clock  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port scan_tick  input  1  one-clock enable pulse that paces scanning and sampling.
REQ-005 SHALL have port col  input  3  keypad column lines, active-low, asynchronous to clock.
REQ-006 SHALL have port row  output  4  keypad row drive, active-low, one-hot-zero.
REQ-007 SHALL have port key  output  4  debounced digit 0..9 while a key is held; 10 (NOKEY) otherwise.
REQ-008 SHALL have port key_valid  output  1  one-clock pulse when a new key is accepted.

Function
REQ-009 SHALL pass col through a 2-flop synchronizer; all col references below mean the synchronized value.
REQ-010 SHALL use this key map, with columns 0..2 left to right: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#.
REQ-011 SHALL implement the states SCAN, DEBOUNCE, HELD and RELEASE; the FSM and the counter act only in clocks where scan_tick=1, except for reset.
REQ-012 SCAN: on a tick with col=3'b111, or more than one col bit low, or only * or # low, the FSM SHALL rotate row 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-013 SCAN: on a tick with exactly one col bit low at a digit position, the FSM SHALL freeze row, latch the row and col index, set cnt=1 and go to DEBOUNCE.
REQ-014 DEBOUNCE: on a tick where col equals the latched one-low pattern, the FSM SHALL increment cnt; when cnt reaches DEBOUNCE it SHALL go to HELD.
REQ-015 DEBOUNCE: on a tick where col differs from the latched pattern, the FSM SHALL clear cnt, advance row to the next row and go to SCAN; key SHALL be unchanged and no key_valid pulse SHALL occur.
REQ-016 On entry to HELD, key SHALL take the decoded digit in the same registered update, and key_valid SHALL be 1 for exactly that one clock.
REQ-017 HELD: on a tick where the latched column is high, the FSM SHALL set cnt=1 and go to RELEASE; other column bits changing SHALL be ignored.
REQ-018 RELEASE: on a tick where the latched column is high, the FSM SHALL increment cnt; when cnt reaches DEBOUNCE, key SHALL become 10, cnt SHALL clear, row SHALL advance and the FSM SHALL go to SCAN.
REQ-019 RELEASE: on a tick where the latched column is low, the FSM SHALL clear cnt and return to HELD; key SHALL be unchanged and no new key_valid pulse SHALL occur.
REQ-020 key SHALL change only on entry to HELD (to a digit) or on exit from RELEASE (to 10); it SHALL never glitch through other values.
REQ-021 row SHALL change only in SCAN ticks and on the exits of REQ-015 and REQ-018, and SHALL always hold exactly one bit low.
REQ-022 Press latency SHALL be DEBOUNCE ticks from the first detecting tick; release latency SHALL be DEBOUNCE ticks from the first high sample.
REQ-023 When scan_tick is held at 1 continuously, the block SHALL still behave per REQ-012..REQ-019, one step per clock.
REQ-024 cnt SHALL be 4 bits wide and SHALL never exceed DEBOUNCE.

Reset
REQ-025 On reset assertion, outputs SHALL immediately take row=4'b1110, key=4'd10, key_valid=0, and the internal state SHALL take state=SCAN, cnt=0, synchronizer=3'b111.
REQ-026 Reset asserted in any state, including mid-debounce or HELD, SHALL abort the operation with no key_valid pulse; after release, scanning SHALL restart at row0.
REQ-027 The first scan_tick after reset deassertion SHALL be processed normally.

Verification
REQ-028 Press digit 5 (col=3'b101 when row=4'b1101) with DEBOUNCE=4 and a stable hold -> key=5 with one key_valid pulse 4 ticks after first detection; release -> key=10 4 ticks after first high sample.
REQ-029 Bounce: col low on 2 ticks, high on 1 tick, then stable -> no accept at the 3rd tick, rescan, and a single key_valid pulse once 4 consecutive matching samples are seen.
REQ-030 Release bounce: in HELD, latched column high on 2 ticks then low -> return to HELD, key stays, no second key_valid pulse.
REQ-031 Press * or #, or two keys in the same row (col=3'b100) -> key stays 10, row keeps rotating, key_valid=0.
REQ-032 Press 0 (row3, col1) -> key=0, which is not NOKEY; reset asserted in HELD -> key=10, row=1110 immediately.
REQ-033 With scan_tick=0 for 100 clocks during a press -> row, key and state unchanged.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner: rotates an active-low row strobe, debounces a single
// digit press and its release, and reports the digit with a one-clock valid pulse.
module keypad_scan #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_tick,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid
);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE);
  localparam logic [3:0] NOKEY  = 4'd10;

  logic [2:0] sync1_q, col_q;
  state_t     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_q, key_d;
  logic [3:0] digit_q, digit_d;
  logic [2:0] lat_q, lat_d;
  logic       kv_q, kv_d;

  logic       one_low, digit_ok, lat_high;
  logic [1:0] cidx, ridx;
  logic [3:0] digit_now, cnt_inc, row_rot;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 3'b111;
      col_q   <= 3'b111;
    end else begin
      sync1_q <= col;
      col_q   <= sync1_q;
    end
  end

  always_comb begin
    one_low = 1'b1;
    cidx    = 2'd0;
    case (col_q)
      3'b110:  cidx = 2'd0;
      3'b101:  cidx = 2'd1;
      3'b011:  cidx = 2'd2;
      default: one_low = 1'b0;
    endcase
    ridx = 2'd0;
    case (row_q)
      4'b1101: ridx = 2'd1;
      4'b1011: ridx = 2'd2;
      4'b0111: ridx = 2'd3;
      default: ridx = 2'd0;
    endcase
  end

  // Row 3 holds * / 0 / #; only its middle column is a digit.
  assign digit_ok  = one_low && ((ridx != 2'd3) || (cidx == 2'd1));
  assign digit_now = (ridx == 2'd3) ? 4'd0
                   : ({2'b00, ridx} * 4'd3) + {2'b00, cidx} + 4'd1;
  // Latched column is high when no low bit of col coincides with the latched low bit.
  assign lat_high  = ~|(~col_q & ~lat_q);
  assign cnt_inc   = cnt_q + 4'd1;
  assign row_rot   = {row_q[2:0], row_q[3]};

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    digit_d = digit_q;
    lat_d   = lat_q;
    kv_d    = 1'b0;
    if (scan_tick) begin
      case (state_q)
        S_SCAN: begin
          if (digit_ok) begin
            lat_d   = col_q;
            digit_d = digit_now;
            cnt_d   = 4'd1;
            state_d = S_DEBOUNCE;
          end else begin
            row_d = row_rot;
          end
        end
        S_DEBOUNCE: begin
          if (col_q == lat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              key_d   = digit_q;
              kv_d    = 1'b1;
              state_d = S_HELD;
            end
          end else begin
            cnt_d   = 4'd0;
            row_d   = row_rot;
            state_d = S_SCAN;
          end
        end
        S_HELD: begin
          if (lat_high) begin
            cnt_d   = 4'd1;
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (lat_high) begin
            if (cnt_inc == DB_MAX) begin
              key_d   = NOKEY;
              cnt_d   = 4'd0;
              row_d   = row_rot;
              state_d = S_SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = S_HELD;
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_SCAN;
      row_q   <= 4'b1110;
      cnt_q   <= 4'd0;
      key_q   <= NOKEY;
      digit_q <= NOKEY;
      lat_q   <= 3'b111;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      digit_q <= digit_d;
      lat_q   <= lat_d;
      kv_q    <= kv_d;
    end
  end

  assign row       = row_q;
  assign key       = key_q;
  assign key_valid = kv_q;

endmodule
